// File: rtl/hazard_stall_controller.sv
// Hazard/stall controller for a 5-stage pipeline: operand forwarding selects,
// load-use and branch-in-ID stalls, and the syscall drain/release sequence.

module hazard_fwd_sel (
  input  logic [4:0] src,
  input  logic       src_used,
  input  logic [4:0] exe_wreg,
  input  logic       exe_rw,
  input  logic       exe_mr,
  input  logic [4:0] mem_wreg,
  input  logic       mem_rw,
  output logic       hit_exe,
  output logic       hit_mem,
  output logic [1:0] sel
);
  // r0 is hardwired to zero, so a write to it never forwards or stalls.
  assign hit_exe = src_used && exe_rw && (exe_wreg == src) && (src != 5'd0);
  assign hit_mem = src_used && mem_rw && (mem_wreg == src) && (src != 5'd0);

  always_comb begin
    sel = 2'd0;
    if (hit_exe && !exe_mr) sel = 2'd1;
    else if (hit_mem)       sel = 2'd2;
  end
endmodule

module hazard_stall_controller #(
  parameter int SYS_DRAIN_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  ID_RegA,
  input  logic [4:0]  ID_RegB,
  input  logic        ID_UsesB,
  input  logic        ID_BranchJR,
  input  logic        ID_Syscall,
  input  logic [4:0]  EXE_WriteReg,
  input  logic        EXE_RegWrite,
  input  logic        EXE_MemRead,
  input  logic [4:0]  MEM_WriteReg,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemRead,
  output logic        Freeze_IF,
  output logic        Bubble_ID,
  output logic [1:0]  Sel_A,
  output logic [1:0]  Sel_B,
  output logic        SYS_Pulse,
  output logic [2:0]  State,
  output logic [31:0] Stall_Count
);
  localparam int NUM_SRC = 2;

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] STALL       = 3'd1;
  localparam logic [2:0] SYS_DRAIN   = 3'd2;
  localparam logic [2:0] SYS_RELEASE = 3'd3;

  localparam logic [2:0] DRAIN_LOAD = 3'(SYS_DRAIN_CYCLES - 1);

  logic [NUM_SRC-1:0][4:0] src_reg;
  logic [NUM_SRC-1:0]      src_used;
  logic [NUM_SRC-1:0]      hit_exe;
  logic [NUM_SRC-1:0]      hit_mem;
  logic [NUM_SRC-1:0][1:0] sel;

  assign src_reg  = {ID_RegB, ID_RegA};
  assign src_used = {ID_UsesB, 1'b1};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_fwd_sel u_fwd (
      .src      (src_reg[i]),
      .src_used (src_used[i]),
      .exe_wreg (EXE_WriteReg),
      .exe_rw   (EXE_RegWrite),
      .exe_mr   (EXE_MemRead),
      .mem_wreg (MEM_WriteReg),
      .mem_rw   (MEM_RegWrite),
      .hit_exe  (hit_exe[i]),
      .hit_mem  (hit_mem[i]),
      .sel      (sel[i])
    );
  end

  assign Sel_A = sel[0];
  assign Sel_B = sel[1];

  logic m_exe, m_mem;
  assign m_exe = |hit_exe;
  assign m_mem = |hit_mem;

  logic [1:0] hz;
  always_comb begin
    hz = 2'd0;
    if (ID_BranchJR && m_exe && EXE_MemRead)
      hz = 2'd2;
    else if ((m_exe && EXE_MemRead) || (ID_BranchJR && m_exe) ||
             (ID_BranchJR && m_mem && MEM_MemRead))
      hz = 2'd1;
  end

  logic [2:0] st, st_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       frz;

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    frz     = 1'b0;
    case (st)
      IDLE: begin
        if (hz != 2'd0) begin
          frz = 1'b1;
          if (hz == 2'd2) begin
            st_nxt  = STALL;
            cnt_nxt = 3'(hz) - 3'd1;
          end
        end else if (ID_Syscall) begin
          frz     = 1'b1;
          st_nxt  = SYS_DRAIN;
          cnt_nxt = DRAIN_LOAD;
        end
      end
      STALL: begin
        frz = 1'b1;
        if (cnt <= 3'd1) begin
          cnt_nxt = 3'd0;
          st_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      // Hazards are deliberately not looked at here; the drain runs to completion.
      SYS_DRAIN: begin
        frz = 1'b1;
        if (cnt <= 3'd1) begin
          cnt_nxt = 3'd0;
          st_nxt  = SYS_RELEASE;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      SYS_RELEASE: begin
        cnt_nxt = 3'd0;
        st_nxt  = IDLE;
      end
      default: begin
        cnt_nxt = 3'd0;
        st_nxt  = IDLE;
      end
    endcase
  end

  // Reset holds the state at IDLE, but a live hazard must not freeze the pipe.
  assign Freeze_IF = frz && !RESET;
  assign Bubble_ID = Freeze_IF;
  assign State     = st;

  // The pulse is set on the edge that loads cnt=2, so it lands in the
  // second-to-last freeze cycle of the drain.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st          <= IDLE;
      cnt         <= 3'd0;
      SYS_Pulse   <= 1'b0;
      Stall_Count <= 32'd0;
    end else begin
      st        <= st_nxt;
      cnt       <= cnt_nxt;
      SYS_Pulse <= (st_nxt == SYS_DRAIN) && (cnt_nxt == 3'd2);
      if (Freeze_IF && (Stall_Count != 32'hFFFF_FFFF))
        Stall_Count <= Stall_Count + 32'd1;
    end
  end
endmodule
